// File: rtl/npc_ctrl_fsm.sv
// npc_ctrl_fsm: multi-cycle control FSM for a simple RV32 core.
// Sequences IDLE->FETCH->DECODE->EXEC->(MEM)->WB, with HALT on ebreak and
// ERR on illegal opcodes.
// Ports: clk, rst_n (async, active-low), start, ifu_req/ifu_valid/inst,
// ir_we, exe_en, lsu_req/lsu_we/lsu_done, rf_we, pc_we, state, halt, err,
// retired.
// Build option: define NPC_CTRL_TIMEOUT_EN to add a FETCH/MEM wait timeout
// of TIMEOUT_CYCLES cycles that routes the FSM to ERR.
module npc_ctrl_fsm #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        ifu_req,
    input  logic        ifu_valid,
    input  logic [31:0] inst,
    output logic        ir_we,
    output logic        exe_en,
    output logic        lsu_req,
    output logic        lsu_we,
    input  logic        lsu_done,
    output logic        rf_we,
    output logic        pc_we,
    output logic [2:0]  state,
    output logic        halt,
    output logic        err,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_t      st;
    state_t      nxt;
    logic [31:0] ir;
    logic [6:0]  op;
    logic        legal;
    logic        is_mem;
    logic        tmo_hit;

    assign op     = ir[6:0];
    assign is_mem = (op == OP_LOAD) || (op == OP_STORE);

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_OP: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

`ifdef NPC_CTRL_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // The limit cycle is the one in which the count would reach the limit;
    // a handshake in that same cycle takes priority in the next-state logic.
    assign tmo_hit = ({1'b0, wait_cnt} + 9'd1) == 9'(TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if (nxt != st) begin
            wait_cnt <= 8'd0;
        end else if (st == S_FETCH || st == S_MEM) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        nxt = st;
        unique case (st)
            S_IDLE: begin
                if (start) nxt = S_FETCH;
            end
            S_FETCH: begin
                if (ifu_valid)    nxt = S_DECODE;
                else if (tmo_hit) nxt = S_ERR;
            end
            S_DECODE: begin
                if (ir == EBREAK) nxt = S_HALT;
                else if (legal)   nxt = S_EXEC;
                else              nxt = S_ERR;
            end
            S_EXEC: begin
                nxt = is_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (lsu_done)     nxt = S_WB;
                else if (tmo_hit) nxt = S_ERR;
            end
            S_WB:   nxt = S_FETCH;
            S_HALT: nxt = S_HALT;
            S_ERR:  nxt = S_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= S_IDLE;
            ir      <= 32'd0;
            retired <= 32'd0;
        end else begin
            st <= nxt;
            if (st == S_FETCH && ifu_valid) ir <= inst;
            if (st == S_WB) retired <= retired + 32'd1;
        end
    end

    assign state   = st;
    assign ifu_req = (st == S_FETCH);
    assign ir_we   = (st == S_FETCH) && ifu_valid;
    assign exe_en  = (st == S_EXEC);
    assign lsu_req = (st == S_MEM);
    assign lsu_we  = (st == S_MEM) && (op == OP_STORE);
    assign pc_we   = (st == S_WB);
    // Branches and stores have no destination register.
    assign rf_we   = (st == S_WB) && legal &&
                     (op != OP_BRANCH) && (op != OP_STORE);
    assign halt    = (st == S_HALT);
    assign err     = (st == S_ERR);

endmodule

// File: tb/tb_npc_ctrl_fsm.sv
// tb_npc_ctrl_fsm: directed table-driven bench for npc_ctrl_fsm.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_npc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ifu_req;
    logic        ifu_valid;
    logic [31:0] inst;
    logic        ir_we;
    logic        exe_en;
    logic        lsu_req;
    logic        lsu_we;
    logic        lsu_done;
    logic        rf_we;
    logic        pc_we;
    logic [2:0]  state;
    logic        halt;
    logic        err;
    logic [31:0] retired;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    npc_ctrl_fsm #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ifu_req   (ifu_req),
        .ifu_valid (ifu_valid),
        .inst      (inst),
        .ir_we     (ir_we),
        .exe_en    (exe_en),
        .lsu_req   (lsu_req),
        .lsu_we    (lsu_we),
        .lsu_done  (lsu_done),
        .rf_we     (rf_we),
        .pc_we     (pc_we),
        .state     (state),
        .halt      (halt),
        .err       (err),
        .retired   (retired)
    );

    // Output bit order: ifu_req ir_we exe_en lsu_req lsu_we rf_we pc_we halt err
    localparam logic [8:0] O_NONE = 9'h000;
    localparam logic [8:0] O_IFU  = 9'h100;
    localparam logic [8:0] O_IRW  = 9'h080;
    localparam logic [8:0] O_EXE  = 9'h040;
    localparam logic [8:0] O_LSU  = 9'h020;
    localparam logic [8:0] O_LWE  = 9'h010;
    localparam logic [8:0] O_RF   = 9'h008;
    localparam logic [8:0] O_PC   = 9'h004;
    localparam logic [8:0] O_HLT  = 9'h002;
    localparam logic [8:0] O_ERR  = 9'h001;

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_SW   = 32'h0011_2023;
    localparam logic [31:0] I_LW   = 32'h0000_2083;
    localparam logic [31:0] I_BEQ  = 32'h0000_0063;
    localparam logic [31:0] I_EBRK = 32'h0010_0073;
    localparam logic [31:0] I_ECAL = 32'h0000_0073;
    localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;

    typedef struct {
        logic        start;
        logic        valid;
        logic [31:0] inst;
        logic        done;
        logic [2:0]  st;
        logic [8:0]  outs;
        logic [31:0] ret;
    } vec_t;

    vec_t tbl[27];

    function automatic logic [8:0] outs_now();
        return {ifu_req, ir_we, exe_en, lsu_req, lsu_we,
                rf_we, pc_we, halt, err};
    endfunction

    task automatic chk(input string name, input logic [2:0] es,
                       input logic [8:0] eo, input logic [31:0] er);
        logic [8:0] o;
        o = outs_now();
        total++;
        if (state === es && o === eo && retired === er) begin
            passed++;
        end else begin
            $display("FAIL %s: got state=%0d outs=%b retired=%0d, want state=%0d outs=%b retired=%0d",
                     name, state, o, retired, es, eo, er);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic [31:0] i,
                        input logic d, input string name,
                        input logic [2:0] es, input logic [8:0] eo,
                        input logic [31:0] er);
        @(negedge clk);
        start     = s;
        ifu_valid = v;
        inst      = i;
        lsu_done  = d;
        #1;
        chk(name, es, eo, er);
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        chk(name, 3'd0, O_NONE, 32'd0);
        @(negedge clk);
        start     = 1'b0;
        ifu_valid = 1'b0;
        inst      = 32'd0;
        lsu_done  = 1'b0;
        rst_n     = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        ifu_valid = 1'b0;
        inst      = 32'd0;
        lsu_done  = 1'b0;

        tbl[0]  = '{0, 0, 32'd0,  0, 3'd0, O_NONE,        32'd0};
        tbl[1]  = '{1, 0, 32'd0,  0, 3'd0, O_NONE,        32'd0};
        tbl[2]  = '{0, 1, I_ADDI, 0, 3'd1, O_IFU | O_IRW, 32'd0};
        tbl[3]  = '{0, 0, I_BAD,  0, 3'd2, O_NONE,        32'd0};
        tbl[4]  = '{0, 0, 32'd0,  0, 3'd3, O_EXE,         32'd0};
        tbl[5]  = '{0, 0, 32'd0,  0, 3'd5, O_RF | O_PC,   32'd0};
        tbl[6]  = '{1, 0, 32'd0,  0, 3'd1, O_IFU,         32'd1};
        tbl[7]  = '{0, 1, I_SW,   0, 3'd1, O_IFU | O_IRW, 32'd1};
        tbl[8]  = '{0, 0, 32'd0,  0, 3'd2, O_NONE,        32'd1};
        tbl[9]  = '{0, 0, 32'd0,  0, 3'd3, O_EXE,         32'd1};
        tbl[10] = '{0, 0, 32'd0,  0, 3'd4, O_LSU | O_LWE, 32'd1};
        tbl[11] = '{0, 1, 32'd0,  0, 3'd4, O_LSU | O_LWE, 32'd1};
        tbl[12] = '{0, 0, 32'd0,  1, 3'd4, O_LSU | O_LWE, 32'd1};
        tbl[13] = '{0, 0, 32'd0,  0, 3'd5, O_PC,          32'd1};
        tbl[14] = '{0, 1, I_LW,   0, 3'd1, O_IFU | O_IRW, 32'd2};
        tbl[15] = '{0, 0, 32'd0,  1, 3'd2, O_NONE,        32'd2};
        tbl[16] = '{0, 0, 32'd0,  0, 3'd3, O_EXE,         32'd2};
        tbl[17] = '{0, 0, 32'd0,  1, 3'd4, O_LSU,         32'd2};
        tbl[18] = '{0, 0, 32'd0,  0, 3'd5, O_RF | O_PC,   32'd2};
        tbl[19] = '{0, 1, I_BEQ,  0, 3'd1, O_IFU | O_IRW, 32'd3};
        tbl[20] = '{0, 0, 32'd0,  0, 3'd2, O_NONE,        32'd3};
        tbl[21] = '{0, 0, 32'd0,  0, 3'd3, O_EXE,         32'd3};
        tbl[22] = '{0, 0, 32'd0,  0, 3'd5, O_PC,          32'd3};
        tbl[23] = '{0, 1, I_BAD,  0, 3'd1, O_IFU | O_IRW, 32'd4};
        tbl[24] = '{0, 0, 32'd0,  0, 3'd2, O_NONE,        32'd4};
        tbl[25] = '{0, 0, 32'd0,  0, 3'd7, O_ERR,         32'd4};
        tbl[26] = '{1, 1, I_ADDI, 1, 3'd7, O_ERR,         32'd4};

        #1;
        chk("reset", 3'd0, O_NONE, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 27; k++) begin
            step(tbl[k].start, tbl[k].valid, tbl[k].inst, tbl[k].done,
                 $sformatf("vec%0d", k), tbl[k].st, tbl[k].outs, tbl[k].ret);
        end

        // ebreak: terminal HALT, later fetch handshakes ignored
        do_reset("rst_ebrk");
        step(1, 0, 32'd0,  0, "eb_idle",  3'd0, O_NONE, 32'd0);
        step(0, 1, I_EBRK, 0, "eb_fetch", 3'd1, O_IFU | O_IRW, 32'd0);
        step(0, 0, 32'd0,  0, "eb_dec",   3'd2, O_NONE, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, I_ADDI, 1, $sformatf("eb_halt%0d", k),
                 3'd6, O_HLT, 32'd0);
        end

        // other SYSTEM encodings are illegal
        do_reset("rst_ecall");
        step(1, 0, 32'd0,  0, "ec_idle",  3'd0, O_NONE, 32'd0);
        step(0, 1, I_ECAL, 0, "ec_fetch", 3'd1, O_IFU | O_IRW, 32'd0);
        step(0, 0, 32'd0,  0, "ec_dec",   3'd2, O_NONE, 32'd0);
        step(0, 0, 32'd0,  0, "ec_err",   3'd7, O_ERR,  32'd0);

        // reset asserted mid-MEM with retired nonzero
        do_reset("rst_mm");
        step(1, 0, 32'd0,  0, "mm_idle", 3'd0, O_NONE, 32'd0);
        step(0, 1, I_ADDI, 0, "mm_f0",   3'd1, O_IFU | O_IRW, 32'd0);
        step(0, 0, 32'd0,  0, "mm_d0",   3'd2, O_NONE, 32'd0);
        step(0, 0, 32'd0,  0, "mm_e0",   3'd3, O_EXE, 32'd0);
        step(0, 0, 32'd0,  0, "mm_w0",   3'd5, O_RF | O_PC, 32'd0);
        step(0, 1, I_SW,   0, "mm_f1",   3'd1, O_IFU | O_IRW, 32'd1);
        step(0, 0, 32'd0,  0, "mm_d1",   3'd2, O_NONE, 32'd0 + 32'd1);
        step(0, 0, 32'd0,  0, "mm_e1",   3'd3, O_EXE, 32'd1);
        step(0, 0, 32'd0,  0, "mm_mem",  3'd4, O_LSU | O_LWE, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mm_async", 3'd0, O_NONE, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        lsu_done = 1'b1;
        #1;
        chk("mm_rel", 3'd0, O_NONE, 32'd0);
        step(0, 1, I_ADDI, 1, "mm_late0", 3'd0, O_NONE, 32'd0);
        step(0, 0, 32'd0,  0, "mm_late1", 3'd0, O_NONE, 32'd0);

        // reset asserted mid-FETCH while ifu_valid is high
        do_reset("rst_mf");
        step(1, 0, 32'd0,  0, "mf_idle",  3'd0, O_NONE, 32'd0);
        step(0, 1, I_ADDI, 0, "mf_fetch", 3'd1, O_IFU | O_IRW, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mf_async", 3'd0, O_NONE, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, I_ADDI, 0, "mf_idle2", 3'd0, O_NONE, 32'd0);

`ifdef NPC_CTRL_TIMEOUT_EN
        do_reset("rst_to");
        step(1, 0, 32'd0, 0, "to_idle", 3'd0, O_NONE, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 32'd0, 0, $sformatf("to_wait%0d", k),
                 3'd1, O_IFU, 32'd0);
        end
        step(0, 0, 32'd0, 0, "to_err", 3'd7, O_ERR, 32'd0);

        do_reset("rst_to2");
        step(1, 0, 32'd0, 0, "tl_idle", 3'd0, O_NONE, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 32'd0, 0, $sformatf("tl_wait%0d", k),
                 3'd1, O_IFU, 32'd0);
        end
        step(0, 1, I_ADDI, 0, "tl_limit", 3'd1, O_IFU | O_IRW, 32'd0);
        step(0, 0, 32'd0,  0, "tl_dec",   3'd2, O_NONE, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
